// File: rtl/floo_pkg.sv
// Shared link types and constants for the floo credit-flow egress path.
package floo_pkg;

    localparam int unsigned DefaultNumCredits = 2;
    localparam int unsigned MaxVcIdWidth      = 4;

    // VC tag carried on the physical link alongside each flit.
    typedef logic [MaxVcIdWidth-1:0] vc_id_t;

    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? unsigned'($clog2(num)) : 1;
    endfunction

endpackage

// File: rtl/floo_credit_counter.sv
// Per-VC credit counter: starts full, counts down on send and up on credit return,
// saturating at the receiver buffer depth and flagging any excess return.
module floo_credit_counter
    import floo_pkg::*;
#(
    parameter int unsigned NumCredits  = DefaultNumCredits,
    parameter int unsigned CreditWidth = $clog2(NumCredits + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   inc_i,
    input  logic                   dec_i,
    output logic [CreditWidth-1:0] cnt_o,
    output logic                   overflow_o
);

    localparam logic [CreditWidth-1:0] MaxCnt = CreditWidth'(NumCredits);

    logic [CreditWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d      = cnt_q;
        overflow_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == MaxCnt) begin
                    overflow_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= MaxCnt;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    no_send_without_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        dec_i |-> (cnt_q != '0));

endmodule

// File: rtl/floo_credit_tx.sv
// Router egress stage: arbitrates ready-first per-VC requests onto one registered,
// credit-flow-controlled link; ready depends only on the local credit counters.
module floo_credit_tx
    import floo_pkg::*;
#(
    parameter int unsigned  NumVirtChannels = 1,
    parameter type          flit_t          = logic,
    parameter int unsigned  NumCredits      = DefaultNumCredits,
    localparam int unsigned CreditWidth     = $clog2(NumCredits + 1),
    localparam int unsigned VcIdWidth       = idx_width(NumVirtChannels)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic                       valid_o,
    output logic [VcIdWidth-1:0]       vc_o,
    output flit_t                      data_o,
    input  logic [NumVirtChannels-1:0] credit_i,
    output logic                       credit_err_o
);

    logic [NumVirtChannels-1:0] req, grant, overflow;
    logic [CreditWidth-1:0]     cnt [NumVirtChannels];
    logic [VcIdWidth-1:0]       grant_vc;
    logic                       xfer, multi_req;

    logic                 valid_q;
    logic [VcIdWidth-1:0] vc_q;
    flit_t                data_q;
    logic                 err_d, err_q;

    assign req       = valid_i & ready_o;
    assign multi_req = |(req & (req - 1'b1));
    assign xfer      = |grant;

    // Lowest index wins if upstream ever breaks the one-hot promise.
    always_comb begin
        grant    = '0;
        grant_vc = '0;
        for (int unsigned v = 0; v < NumVirtChannels; v++) begin
            if (req[v] && (grant == '0)) begin
                grant[v] = 1'b1;
                grant_vc = VcIdWidth'(v);
            end
        end
    end

    for (genvar v = 0; v < NumVirtChannels; v++) begin : gen_vc
        floo_credit_counter #(
            .NumCredits  (NumCredits),
            .CreditWidth (CreditWidth)
        ) u_credit_counter (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .inc_i      (credit_i[v]),
            .dec_i      (grant[v]),
            .cnt_o      (cnt[v]),
            .overflow_o (overflow[v])
        );

        assign ready_o[v] = (cnt[v] != '0);

        valid_held_until_ready: assert property (@(posedge clk_i) disable iff (rst_i)
            (valid_i[v] && !ready_o[v]) |=> valid_i[v]);
    end

    assign err_d = err_q | multi_req | (|overflow);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            vc_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= xfer;
            if (xfer) begin
                vc_q   <= grant_vc;
                data_q <= data_i;
            end
            err_q <= err_d;
        end
    end

    assign valid_o      = valid_q;
    assign vc_o         = vc_q;
    assign data_o       = data_q;
    assign credit_err_o = err_q;

    valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(valid_i));

endmodule

// File: tb/tb_floo_credit_tx.sv
// Bench for floo_credit_tx: directed credit-loop scenarios plus randomized traffic
// checked against a credit-arithmetic reference model.
module tb_floo_credit_tx;

    localparam int unsigned NumVc = 2;
    localparam int unsigned NumCr = 2;

    typedef logic [7:0] flit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  valid_i, ready_o, credit_i;
    flit_t       data_i, data_o;
    logic        valid_o, credit_err_o;
    logic [0:0]  vc_o;

    int checks = 0;
    int passed = 0;

    // Reference model state
    int    m_cred [NumVc];
    logic  m_valid;
    logic  m_vc;
    flit_t m_data;
    logic  m_err;

    always #5 clk = ~clk;

    floo_credit_tx #(
        .NumVirtChannels (NumVc),
        .flit_t          (flit_t),
        .NumCredits      (NumCr)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .vc_o         (vc_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .credit_err_o (credit_err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NumVc; i++) m_cred[i] = NumCr;
        m_valid = 1'b0;
        m_vc    = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    // One link cycle: sender may spend a credit, receiver may return one.
    task automatic model_clock(input logic [1:0] vi, input logic [1:0] ci, input flit_t di);
        int win;
        int nreq;
        win  = -1;
        nreq = 0;
        for (int i = 0; i < NumVc; i++) begin
            if (vi[i] && m_cred[i] > 0) begin
                nreq++;
                if (win < 0) win = i;
            end
        end
        if (nreq > 1) m_err = 1'b1;
        m_valid = (win >= 0);
        if (win >= 0) begin
            m_vc   = (win == 1);
            m_data = di;
        end
        for (int i = 0; i < NumVc; i++) begin
            m_cred[i] = m_cred[i] + int'(ci[i]) - ((win == i) ? 1 : 0);
            if (m_cred[i] > NumCr) begin
                m_cred[i] = NumCr;
                m_err     = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = '0; credit_i = '0; data_i = '0;
        step();
        step();
        rst = 1'b0;
        checks++; if (ready_o !== 2'b11) $display("FAIL reset_ready: got %b want 11", ready_o); else passed++;
        checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
        checks++; if (vc_o !== 1'b0) $display("FAIL reset_vc: got %b want 0", vc_o); else passed++;
        checks++; if (data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", data_o); else passed++;
        checks++; if (credit_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", credit_err_o); else passed++;
    endtask

    task automatic test_back_to_back();
        valid_i = 2'b01; data_i = 8'h0A;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 8'h0A || vc_o !== 1'b0)
            $display("FAIL b2b_flit_a: got v=%b d=%h vc=%b want v=1 d=0a vc=0", valid_o, data_o, vc_o);
        else passed++;
        data_i = 8'h0B;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 8'h0B || vc_o !== 1'b0)
            $display("FAIL b2b_flit_b: got v=%b d=%h vc=%b want v=1 d=0b vc=0", valid_o, data_o, vc_o);
        else passed++;
        checks++; if (ready_o !== 2'b10) $display("FAIL b2b_ready_empty: got %b want 10", ready_o); else passed++;
        data_i = 8'h0C;
        step();
        checks++; if (valid_o !== 1'b0 || data_o !== 8'h0B)
            $display("FAIL b2b_held: got v=%b d=%h want v=0 d=0b", valid_o, data_o);
        else passed++;
        step();
        checks++; if (ready_o !== 2'b10) $display("FAIL b2b_vc1_free: got %b want 10", ready_o); else passed++;
        credit_i = 2'b01;
        step();
        credit_i = 2'b00;
        checks++; if (ready_o !== 2'b11 || valid_o !== 1'b0)
            $display("FAIL b2b_credit_ready: got r=%b v=%b want r=11 v=0", ready_o, valid_o);
        else passed++;
        step();
        valid_i = 2'b00;
        checks++; if (valid_o !== 1'b1 || data_o !== 8'h0C || vc_o !== 1'b0)
            $display("FAIL b2b_flit_c: got v=%b d=%h vc=%b want v=1 d=0c vc=0", valid_o, data_o, vc_o);
        else passed++;
        checks++; if (ready_o !== 2'b10) $display("FAIL b2b_cnt0_zero: got %b want 10", ready_o); else passed++;
    endtask

    task automatic test_same_cycle();
        valid_i = 2'b10; data_i = 8'h11;
        step();
        checks++; if (ready_o !== 2'b10 || vc_o !== 1'b1 || data_o !== 8'h11)
            $display("FAIL same_pre: got r=%b vc=%b d=%h want r=10 vc=1 d=11", ready_o, vc_o, data_o);
        else passed++;
        data_i = 8'h22; credit_i = 2'b10;
        step();
        credit_i = 2'b00;
        checks++; if (ready_o !== 2'b10 || valid_o !== 1'b1 || data_o !== 8'h22)
            $display("FAIL same_cycle: got r=%b v=%b d=%h want r=10 v=1 d=22", ready_o, valid_o, data_o);
        else passed++;
        data_i = 8'h33;
        step();
        valid_i = 2'b00;
        checks++; if (ready_o !== 2'b00 || data_o !== 8'h33)
            $display("FAIL same_drain: got r=%b d=%h want r=00 d=33", ready_o, data_o);
        else passed++;
        checks++; if (credit_err_o !== 1'b0) $display("FAIL same_err: got %b want 0", credit_err_o); else passed++;
    endtask

    task automatic test_reset_midstream();
        rst = 1'b1; credit_i = 2'b11;
        step();
        rst = 1'b0; credit_i = 2'b00;
        checks++; if (ready_o !== 2'b11 || valid_o !== 1'b0 || credit_err_o !== 1'b0)
            $display("FAIL midrst_state: got r=%b v=%b e=%b want r=11 v=0 e=0",
                     ready_o, valid_o, credit_err_o);
        else passed++;
        valid_i = 2'b01; data_i = 8'h05;
        step();
        data_i = 8'h06;
        step();
        valid_i = 2'b00;
        checks++; if (ready_o !== 2'b10 || data_o !== 8'h06)
            $display("FAIL midrst_two_credits: got r=%b d=%h want r=10 d=06", ready_o, data_o);
        else passed++;
        step();
        checks++; if (valid_o !== 1'b0) $display("FAIL midrst_idle: got %b want 0", valid_o); else passed++;
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        step();
        rst = 1'b0; credit_i = 2'b01;
        step();
        credit_i = 2'b00;
        checks++; if (credit_err_o !== 1'b1 || ready_o !== 2'b11)
            $display("FAIL ovf_flag: got e=%b r=%b want e=1 r=11", credit_err_o, ready_o);
        else passed++;
        for (int i = 0; i < 3; i++) step();
        checks++; if (credit_err_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", credit_err_o); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (credit_err_o !== 1'b0) $display("FAIL ovf_clear: got %b want 0", credit_err_o); else passed++;
    endtask

    task automatic test_random(input int n);
        int          hold;
        int          s;
        flit_t       hold_data;
        flit_t       di;
        logic [1:0]  vi, ci, exp_ready;
        hold = -1;
        hold_data = '0;
        rst = 1'b1; valid_i = '0; credit_i = '0;
        step();
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < n; cyc++) begin
            vi = '0;
            ci = '0;
            di = flit_t'($urandom);
            if (hold >= 0) begin
                vi[hold] = 1'b1;
                di = hold_data;
                if (m_cred[hold] > 0) hold = -1;
            end else if ($urandom_range(0, 3) != 0) begin
                s = $urandom_range(0, 1);
                vi[s] = 1'b1;
                if (m_cred[s] == 0) begin
                    hold = s;
                    hold_data = di;
                end
            end
            for (int i = 0; i < NumVc; i++) begin
                if (m_cred[i] < NumCr && $urandom_range(0, 2) == 0) ci[i] = 1'b1;
            end
            valid_i = vi; credit_i = ci; data_i = di;
            model_clock(vi, ci, di);
            step();
            for (int i = 0; i < NumVc; i++) exp_ready[i] = (m_cred[i] > 0);
            checks++; if (valid_o !== m_valid)
                $display("FAIL rnd_valid @%0d: got %b want %b", cyc, valid_o, m_valid);
            else passed++;
            checks++; if (vc_o !== m_vc || data_o !== m_data)
                $display("FAIL rnd_flit @%0d: got vc=%b d=%h want vc=%b d=%h", cyc, vc_o, data_o, m_vc, m_data);
            else passed++;
            checks++; if (ready_o !== exp_ready)
                $display("FAIL rnd_ready @%0d: got %b want %b", cyc, ready_o, exp_ready);
            else passed++;
            checks++; if (credit_err_o !== m_err)
                $display("FAIL rnd_err @%0d: got %b want %b", cyc, credit_err_o, m_err);
            else passed++;
        end
        rst = 1'b1; valid_i = '0; credit_i = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_same_cycle();
        test_reset_midstream();
        test_overflow();
        test_random(400);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
